// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: command codes, FSM states, widths.
package pc_seq_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP    = 3'd0,
    CMD_INC    = 3'd1,
    CMD_BRANCH = 3'd2,
    CMD_JMPABS = 3'd3,
    CMD_LOAD   = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BR_FIX = 2'd1,
    ST_JMP_LO = 2'd2,
    ST_JMP_HI = 2'd3
  } state_e;

  // Adjust the page byte by one in the latched branch direction.
  function automatic logic [BYTE_W-1:0] page_step(input logic [BYTE_W-1:0] pch, input logic up);
    return up ? BYTE_W'(pch + BYTE_W'(1)) : BYTE_W'(pch - BYTE_W'(1));
  endfunction

endpackage

// File: rtl/pc_sequencer_adder.sv
// 8-bit low-byte adder for relative branches; flags when the signed displacement leaves the page.
module pc_byte_adder
  import pc_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              carry_o,
  output logic              page_cross_o
);

  logic [BYTE_W:0] full_sum;

  assign full_sum     = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o        = full_sum[BYTE_W-1:0];
  assign carry_o      = full_sum[BYTE_W];
  // Forward offset crosses on carry, backward offset crosses on missing carry.
  assign page_cross_o = b_i[BYTE_W-1] ^ full_sum[BYTE_W];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, load, two-byte absolute jump and relative branch,
// with an extra page-fix cycle when a branch leaves the current page. All advances gated by RDY.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        PHI0,
  input  logic        RES,
  input  logic        RDY,
  input  logic        CMD_VALID,
  input  logic [2:0]  CMD,
  output logic        CMD_READY,
  input  logic        TAKEN,
  input  logic [7:0]  OFFSET,
  input  logic [7:0]  ADL,
  input  logic [7:0]  ADH,
  input  logic [7:0]  DL,
  output logic [15:0] PC,
  output logic        BUSY,
  output logic        PAGE_FIX,
  output logic        DONE
);

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [BYTE_W-1:0]   temp_q;
  logic                dir_up_q;
  logic                done_q;

  logic [BYTE_W-1:0]   br_sum;
  logic                br_carry;
  logic                br_cross;

  pc_byte_adder u_br_add (
    .a_i          (pc_q[BYTE_W-1:0]),
    .b_i          (OFFSET),
    .sum_o        (br_sum),
    .carry_o      (br_carry),
    .page_cross_o (br_cross)
  );

  // Sequencer state, PC and completion pulse; everything freezes while RDY is low.
  always_ff @(posedge PHI0 or posedge RES) begin
    if (RES) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      temp_q   <= '0;
      dir_up_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (RDY) begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (CMD_VALID) begin
            done_q <= 1'b1;
            case (CMD)
              CMD_INC:  pc_q <= PC_W'(pc_q + PC_W'(1));
              CMD_LOAD: pc_q <= {ADH, ADL};
              CMD_BRANCH: begin
                if (TAKEN) begin
                  pc_q[BYTE_W-1:0] <= br_sum;
                  // A crossing branch's carry tells the page direction.
                  if (br_cross) begin
                    dir_up_q <= br_carry;
                    state_q  <= ST_BR_FIX;
                    done_q   <= 1'b0;
                  end
                end
              end
              CMD_JMPABS: begin
                state_q <= ST_JMP_LO;
                done_q  <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_BR_FIX: begin
          pc_q[PC_W-1:BYTE_W] <= page_step(pc_q[PC_W-1:BYTE_W], dir_up_q);
          state_q             <= ST_IDLE;
          done_q              <= 1'b1;
        end
        ST_JMP_LO: begin
          temp_q  <= DL;
          pc_q    <= PC_W'(pc_q + PC_W'(1));
          state_q <= ST_JMP_HI;
        end
        ST_JMP_HI: begin
          pc_q    <= {DL, temp_q};
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CMD_READY = (state_q == ST_IDLE) & RDY & ~RES;
  assign PC        = pc_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign PAGE_FIX  = (state_q == ST_BR_FIX);
  assign DONE      = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer: the driver predicts each command's final PC and
// latency from plain address arithmetic; a negedge monitor checks them whenever DONE reports.
module tb_pc_sequencer;

  localparam logic [2:0] C_NOP = 3'd0, C_INC = 3'd1, C_BR = 3'd2, C_JMP = 3'd3, C_LOAD = 3'd4;
  localparam logic [15:0] RST_PC = 16'h0400;

  logic        clk = 1'b0;
  logic        RES, RDY, CMD_VALID, TAKEN, CMD_READY, BUSY, PAGE_FIX, DONE;
  logic [2:0]  CMD;
  logic [7:0]  OFFSET, ADL, ADH, DL;
  logic [15:0] PC;

  typedef struct {
    logic [15:0] pc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_pc;
  bit          drv_issue = 1'b0;

  bit          prev_adv = 1'b0, prev_acc = 1'b0, mon_inflight = 1'b0;
  int          mon_cnt = 0;
  exp_t        mon_e;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .PHI0(clk), .RES(RES), .RDY(RDY), .CMD_VALID(CMD_VALID), .CMD(CMD), .CMD_READY(CMD_READY),
    .TAKEN(TAKEN), .OFFSET(OFFSET), .ADL(ADL), .ADH(ADH), .DL(DL), .PC(PC), .BUSY(BUSY),
    .PAGE_FIX(PAGE_FIX), .DONE(DONE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference: final PC is plain address arithmetic; a branch costs a second cycle iff it leaves the page.
  function automatic void model(input logic [2:0] c, input bit tk, input logic [7:0] off,
                                input logic [7:0] adl, input logic [7:0] adh, input logic [7:0] lo,
                                input logic [7:0] hi, input logic [15:0] pc,
                                output logic [15:0] tgt, output int lat, output logic [15:0] m1,
                                output logic [15:0] m2, output bit cr);
    tgt = pc; lat = 1; m1 = pc; m2 = pc; cr = 1'b0;
    case (c)
      C_INC:  tgt = pc + 16'd1;
      C_LOAD: tgt = {adh, adl};
      C_BR: if (tk) begin
        tgt = pc + {{8{off[7]}}, off};
        cr  = (tgt[15:8] != pc[15:8]);
        lat = cr ? 2 : 1;
        m1  = cr ? {pc[15:8], tgt[7:0]} : tgt;
      end
      C_JMP: begin
        tgt = {hi, lo}; lat = 3; m1 = pc; m2 = pc + 16'd1;
      end
      default: ;
    endcase
  endfunction

  // Issue one command, then walk its busy cycles under the given RDY pattern.
  task automatic run_cmd(input logic [2:0] c, input bit tk, input logic [7:0] off,
                         input logic [7:0] adl, input logic [7:0] adh, input logic [7:0] lo,
                         input logic [7:0] hi, input logic [15:0] rdy_mask);
    logic [15:0] tgt, m1, m2, e;
    int          lat, adv;
    bit          cr, r;
    exp_t        ent;
    model(c, tk, off, adl, adh, lo, hi, model_pc, tgt, lat, m1, m2, cr);
    ent.pc = tgt; ent.lat = lat;
    exp_q.push_back(ent);
    CMD = c; TAKEN = tk; OFFSET = off; ADL = adl; ADH = adh; DL = 8'($urandom);
    CMD_VALID = 1'b1; RDY = 1'b1; drv_issue = 1'b1;
    #1 chk("cmd_ready_idle", 32'(CMD_READY), 32'd1);
    cyc();
    drv_issue = 1'b0; CMD_VALID = 1'b0;
    adv = 1;
    for (int i = 0; i < 64; i++) begin
      e = (adv == lat) ? tgt : ((adv == 1) ? m1 : m2);
      chk("pc_step", 32'(PC), 32'(e));
      chk("busy_step", 32'(BUSY), 32'(adv < lat));
      chk("page_fix_step", 32'(PAGE_FIX), 32'(cr && adv == 1));
      if (adv == lat) break;
      r = (i < 16) ? rdy_mask[i] : 1'b1;
      RDY = r; CMD_VALID = 1'($urandom); CMD = 3'($urandom); TAKEN = 1'($urandom);
      DL = (c == C_JMP) ? ((adv == 1) ? lo : hi) : 8'($urandom);
      #1 chk("cmd_ready_busy", 32'(CMD_READY), 32'd0);
      cyc();
      if (r) adv++;
    end
    CMD_VALID = 1'b0;
    model_pc = tgt;
  endtask

  // Idle cycles with no acceptance possible: PC must not move.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      RDY = 1'($urandom); CMD_VALID = !RDY && 1'($urandom); CMD = 3'($urandom);
      #1 chk("cmd_ready_gap", 32'(CMD_READY), 32'(RDY));
      cyc();
      chk("pc_idle_hold", 32'(PC), 32'(model_pc));
      chk("busy_idle", 32'(BUSY), 32'd0);
    end
    CMD_VALID = 1'b0;
  endtask

  // Monitor: counts advancing edges since acceptance and scores each DONE against the queue.
  always @(negedge clk) begin
    if (RES) begin
      mon_inflight = 1'b0; prev_adv = 1'b0; prev_acc = 1'b0;
    end else begin
      if (prev_adv) begin
        if (mon_inflight) mon_cnt++;
        if (prev_acc) begin mon_inflight = 1'b1; mon_cnt = 1; end
      end
      if (DONE && prev_adv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got DONE=1 with nothing outstanding, expected DONE=0 (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_pc", 32'(PC), 32'(mon_e.pc));
          chk("done_latency", 32'(mon_cnt), 32'(mon_e.lat));
        end
        mon_inflight = 1'b0;
      end
      prev_adv = RDY;
      prev_acc = drv_issue && RDY;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RES = 1'b1; RDY = 1'b1; CMD_VALID = 1'b0; CMD = C_NOP; TAKEN = 1'b0;
    OFFSET = '0; ADL = '0; ADH = '0; DL = '0; model_pc = RST_PC;
    repeat (3) @(posedge clk);
    #2;
    chk("pc_in_reset", 32'(PC), 32'(RST_PC));
    chk("cmd_ready_in_reset", 32'(CMD_READY), 32'd0);
    RES = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("pc_after_reset", 32'(PC), 32'(RST_PC));
      chk("busy_after_reset", 32'(BUSY), 32'd0);
      chk("done_after_reset", 32'(DONE), 32'd0);
    end

    // INC wrap
    run_cmd(C_LOAD, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 16'hFFFF);
    run_cmd(C_INC,  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'hFFFF);
    // Forward cross, backward cross, backward no cross, not taken, reserved
    run_cmd(C_LOAD, 1'b0, 8'h00, 8'hF0, 8'h10, 8'h00, 8'h00, 16'hFFFF);
    run_cmd(C_BR,   1'b1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 16'hFFFF);
    run_cmd(C_LOAD, 1'b0, 8'h00, 8'h05, 8'h20, 8'h00, 8'h00, 16'hFFFF);
    run_cmd(C_BR,   1'b1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 16'hFFFF);
    run_cmd(C_LOAD, 1'b0, 8'h00, 8'h85, 8'h20, 8'h00, 8'h00, 16'hFFFF);
    run_cmd(C_BR,   1'b1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 16'hFFFF);
    run_cmd(C_BR,   1'b0, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 16'hFFFF);
    run_cmd(3'd6,   1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'hFFFF);
    // JMPABS with two stalled cycles in JMP_LO
    run_cmd(C_LOAD, 1'b0, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 16'hFFFF);
    run_cmd(C_JMP,  1'b0, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 16'hFFFC);

    // Reset while in JMP_HI
    run_cmd(C_LOAD, 1'b0, 8'h00, 8'h66, 8'h55, 8'h00, 8'h00, 16'hFFFF);
    begin
      exp_t ent;
      ent.pc = 16'hABCD; ent.lat = 3;
      exp_q.push_back(ent);
    end
    CMD = C_JMP; CMD_VALID = 1'b1; RDY = 1'b1; drv_issue = 1'b1;
    cyc();
    drv_issue = 1'b0; CMD_VALID = 1'b0; DL = 8'hCD;
    cyc();
    chk("busy_jmp_hi", 32'(BUSY), 32'd1);
    chk("pc_jmp_hi", 32'(PC), 32'h5567);
    DL = 8'hAB;
    #1 RES = 1'b1;
    #1 chk("pc_async_reset", 32'(PC), 32'(RST_PC));
    exp_q.delete();
    model_pc = RST_PC;
    cyc(); cyc();
    RES = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("busy_post_abort", 32'(BUSY), 32'd0);
      chk("done_post_abort", 32'(DONE), 32'd0);
      chk("pc_post_abort", 32'(PC), 32'(RST_PC));
    end

    // Randomised commands with stalls and ignored CMD_VALID while busy
    for (int n = 0; n < 300; n++) begin
      idle_gap(int'($urandom_range(0, 2)));
      run_cmd(3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), 16'($urandom | $urandom));
    end

    RDY = 1'b1; CMD_VALID = 1'b0;
    cyc(); cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
